// File: rtl/decode.sv
// decode: RV32I instruction decoder stage with registered fields, immediates and format flags
module decode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instruction,
    output logic            out_valid,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm_I,
    output logic [XLEN-1:0] imm_S,
    output logic [XLEN-1:0] imm_B,
    output logic [XLEN-1:0] imm_U,
    output logic [XLEN-1:0] imm_J,
    output logic [XLEN-1:0] imm,
    output logic            is_r,
    output logic            is_i,
    output logic            is_s,
    output logic            is_b,
    output logic            is_u,
    output logic            is_j,
    output logic            illegal
);
    logic [6:0]      opc;
    logic            sgn;
    logic [XLEN-1:0] imm_i_d, imm_s_d, imm_b_d, imm_u_d, imm_j_d, imm_d;
    logic            is_r_d, is_i_d, is_s_d, is_b_d, is_u_d, is_j_d, illegal_d;

    // Unconditional immediate extraction plus opcode classification and format-selected immediate
    always_comb begin
        opc       = instruction[6:0];
        sgn       = instruction[31];
        imm_i_d   = {{20{sgn}}, instruction[31:20]};
        imm_s_d   = {{20{sgn}}, instruction[31:25], instruction[11:7]};
        imm_b_d   = {{19{sgn}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
        imm_u_d   = {instruction[31:12], 12'b0};
        imm_j_d   = {{11{sgn}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};
        is_r_d    = opc == 7'b0110011;
        is_i_d    = opc == 7'b0010011 || opc == 7'b0000011 || opc == 7'b1100111 ||
                    opc == 7'b0001111 || opc == 7'b1110011;
        is_s_d    = opc == 7'b0100011;
        is_b_d    = opc == 7'b1100011;
        is_u_d    = opc == 7'b0110111 || opc == 7'b0010111;
        is_j_d    = opc == 7'b1101111;
        illegal_d = !(is_r_d || is_i_d || is_s_d || is_b_d || is_u_d || is_j_d);
        imm_d     = is_i_d ? imm_i_d :
                    is_s_d ? imm_s_d :
                    is_b_d ? imm_b_d :
                    is_u_d ? imm_u_d :
                    is_j_d ? imm_j_d : '0;
    end

    // Output register: reset clears everything, a valid instruction loads, otherwise hold with out_valid low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            rd        <= '0;
            funct3    <= '0;
            rs1       <= '0;
            rs2       <= '0;
            funct7    <= '0;
            imm_I     <= '0;
            imm_S     <= '0;
            imm_B     <= '0;
            imm_U     <= '0;
            imm_J     <= '0;
            imm       <= '0;
            is_r      <= 1'b0;
            is_i      <= 1'b0;
            is_s      <= 1'b0;
            is_b      <= 1'b0;
            is_u      <= 1'b0;
            is_j      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= instr_valid;
            if (instr_valid) begin
                opcode  <= opc;
                rd      <= instruction[11:7];
                funct3  <= instruction[14:12];
                rs1     <= instruction[19:15];
                rs2     <= instruction[24:20];
                funct7  <= instruction[31:25];
                imm_I   <= imm_i_d;
                imm_S   <= imm_s_d;
                imm_B   <= imm_b_d;
                imm_U   <= imm_u_d;
                imm_J   <= imm_j_d;
                imm     <= imm_d;
                is_r    <= is_r_d;
                is_i    <= is_i_d;
                is_s    <= is_s_d;
                is_b    <= is_b_d;
                is_u    <= is_u_d;
                is_j    <= is_j_d;
                illegal <= illegal_d;
            end
        end
    end
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed self-checking bench for the RV32I decode stage
module tb_decode;
    logic        clk = 1'b0;
    logic        rst, instr_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_I, imm_S, imm_B, imm_U, imm_J, imm;
    logic        is_r, is_i, is_s, is_b, is_u, is_j, illegal;
    int          errors = 0;
    int          checks = 0;

    decode #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
        .out_valid(out_valid), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .imm_I(imm_I), .imm_S(imm_S), .imm_B(imm_B),
        .imm_U(imm_U), .imm_J(imm_J), .imm(imm), .is_r(is_r), .is_i(is_i), .is_s(is_s),
        .is_b(is_b), .is_u(is_u), .is_j(is_j), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // flags packed as {is_r,is_i,is_s,is_b,is_u,is_j,illegal}
    task automatic cycle(input logic r, input logic v, input logic [31:0] ins);
        rst = r;
        instr_valid = v;
        instruction = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b1, 32'h003100B3);
        checks++; if ({out_valid, opcode, rd, funct3, rs1, rs2, funct7} !== 33'd0) begin errors++; $display("FAIL reset_fields got=%h exp=0", {out_valid, opcode, rd, funct3, rs1, rs2, funct7}); end
        checks++; if ({imm_I, imm_S, imm_B, imm_U, imm_J, imm} !== 192'd0) begin errors++; $display("FAIL reset_imms got=%h exp=0", {imm_I, imm_S, imm_B, imm_U, imm_J, imm}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'd0) begin errors++; $display("FAIL reset_flags got=%b exp=0000000", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
    endtask

    task automatic test_r_type;
        cycle(1'b0, 1'b1, 32'h003100B3);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if ({opcode, rd, funct3, rs1, rs2, funct7} !== {7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0}) begin errors++; $display("FAIL add_fields got=%h exp=%h", {opcode, rd, funct3, rs1, rs2, funct7}, {7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0}); end
        checks++; if (imm_I !== 32'h00000003) begin errors++; $display("FAIL add_immI got=%h exp=00000003", imm_I); end
        checks++; if (imm !== 32'h0) begin errors++; $display("FAIL add_imm got=%h exp=00000000", imm); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b1000000) begin errors++; $display("FAIL add_flags got=%b exp=1000000", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
    endtask

    task automatic test_i_type;
        cycle(1'b0, 1'b1, 32'h06410093);
        checks++; if ({imm_I, imm, rd, rs1} !== {32'h64, 32'h64, 5'd1, 5'd2}) begin errors++; $display("FAIL addi_fields got=%h exp=%h", {imm_I, imm, rd, rs1}, {32'h64, 32'h64, 5'd1, 5'd2}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0100000) begin errors++; $display("FAIL addi_flags got=%b exp=0100000", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
        cycle(1'b0, 1'b1, 32'hFFF10093);
        checks++; if ({imm_I, imm} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin errors++; $display("FAIL addi_neg got=%h exp=ffffffffffffffff", {imm_I, imm}); end
    endtask

    task automatic test_i_variants;
        cycle(1'b0, 1'b1, 32'h80012083);
        checks++; if ({imm, is_i, illegal} !== {32'hFFFFF800, 1'b1, 1'b0}) begin errors++; $display("FAIL load got=%h exp=%h", {imm, is_i, illegal}, {32'hFFFFF800, 1'b1, 1'b0}); end
        cycle(1'b0, 1'b1, 32'h00C08067);
        checks++; if ({imm, is_i, is_j, illegal} !== {32'h0000000C, 3'b100}) begin errors++; $display("FAIL jalr got=%h exp=%h", {imm, is_i, is_j, illegal}, {32'h0000000C, 3'b100}); end
        cycle(1'b0, 1'b1, 32'h0FF0000F);
        checks++; if ({imm, is_i, illegal} !== {32'h000000FF, 2'b10}) begin errors++; $display("FAIL fence got=%h exp=%h", {imm, is_i, illegal}, {32'h000000FF, 2'b10}); end
        cycle(1'b0, 1'b1, 32'h00100073);
        checks++; if ({imm, is_i, illegal} !== {32'h00000001, 2'b10}) begin errors++; $display("FAIL system got=%h exp=%h", {imm, is_i, illegal}, {32'h00000001, 2'b10}); end
    endtask

    task automatic test_s_type;
        cycle(1'b0, 1'b1, 32'h00312423);
        checks++; if ({imm_S, imm, rs1, rs2} !== {32'h8, 32'h8, 5'd2, 5'd3}) begin errors++; $display("FAIL sw_fields got=%h exp=%h", {imm_S, imm, rs1, rs2}, {32'h8, 32'h8, 5'd2, 5'd3}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0010000) begin errors++; $display("FAIL sw_flags got=%b exp=0010000", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
    endtask

    task automatic test_b_type;
        cycle(1'b0, 1'b1, 32'h04208163);
        checks++; if ({imm_B, imm, rs1, rs2} !== {32'h42, 32'h42, 5'd1, 5'd2}) begin errors++; $display("FAIL beq_fields got=%h exp=%h", {imm_B, imm, rs1, rs2}, {32'h42, 32'h42, 5'd1, 5'd2}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0001000) begin errors++; $display("FAIL beq_flags got=%b exp=0001000", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
        cycle(1'b0, 1'b1, 32'hFE000EE3);
        checks++; if ({imm_B, imm, funct7} !== {32'hFFFFFFFC, 32'hFFFFFFFC, 7'h7F}) begin errors++; $display("FAIL beq_neg got=%h exp=%h", {imm_B, imm, funct7}, {32'hFFFFFFFC, 32'hFFFFFFFC, 7'h7F}); end
    endtask

    task automatic test_u_type;
        cycle(1'b0, 1'b1, 32'h123450B7);
        checks++; if ({imm_U, imm, rd} !== {32'h12345000, 32'h12345000, 5'd1}) begin errors++; $display("FAIL lui_fields got=%h exp=%h", {imm_U, imm, rd}, {32'h12345000, 32'h12345000, 5'd1}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0000100) begin errors++; $display("FAIL lui_flags got=%b exp=0000100", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
        cycle(1'b0, 1'b1, 32'hFFFFF097);
        checks++; if ({imm, is_u, illegal} !== {32'hFFFFF000, 2'b10}) begin errors++; $display("FAIL auipc got=%h exp=%h", {imm, is_u, illegal}, {32'hFFFFF000, 2'b10}); end
    endtask

    task automatic test_j_type;
        cycle(1'b0, 1'b1, 32'h00A0A0EF);
        checks++; if ({imm_J, imm, rd} !== {32'h0000A00A, 32'h0000A00A, 5'd1}) begin errors++; $display("FAIL jal_fields got=%h exp=%h", {imm_J, imm, rd}, {32'h0000A00A, 32'h0000A00A, 5'd1}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0000010) begin errors++; $display("FAIL jal_flags got=%b exp=0000010", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
    endtask

    task automatic test_hold;
        cycle(1'b0, 1'b0, 32'h06410093);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
        checks++; if ({opcode, rd, imm_J, imm, is_j} !== {7'b1101111, 5'd1, 32'h0000A00A, 32'h0000A00A, 1'b1}) begin errors++; $display("FAIL hold_fields got=%h exp=%h", {opcode, rd, imm_J, imm, is_j}, {7'b1101111, 5'd1, 32'h0000A00A, 32'h0000A00A, 1'b1}); end
    endtask

    task automatic test_illegal;
        cycle(1'b0, 1'b1, 32'h00000000);
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0000001) begin errors++; $display("FAIL zero_flags got=%b exp=0000001", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
        checks++; if (imm !== 32'h0) begin errors++; $display("FAIL zero_imm got=%h exp=00000000", imm); end
        cycle(1'b0, 1'b1, 32'hFFF0007F);
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'b0000001) begin errors++; $display("FAIL ill7f_flags got=%b exp=0000001", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
        checks++; if ({imm_I, imm, opcode} !== {32'hFFFFFFFF, 32'h0, 7'h7F}) begin errors++; $display("FAIL ill7f_imms got=%h exp=%h", {imm_I, imm, opcode}, {32'hFFFFFFFF, 32'h0, 7'h7F}); end
        cycle(1'b0, 1'b1, 32'h00000091);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL low_bits got=%b exp=1", illegal); end
    endtask

    task automatic test_back_to_back;
        cycle(1'b0, 1'b1, 32'h00312423);
        checks++; if ({out_valid, imm, is_s} !== {1'b1, 32'h8, 1'b1}) begin errors++; $display("FAIL b2b_sw got=%h exp=%h", {out_valid, imm, is_s}, {1'b1, 32'h8, 1'b1}); end
        cycle(1'b0, 1'b1, 32'h04208163);
        checks++; if ({out_valid, imm, is_b, is_s} !== {1'b1, 32'h42, 2'b10}) begin errors++; $display("FAIL b2b_beq got=%h exp=%h", {out_valid, imm, is_b, is_s}, {1'b1, 32'h42, 2'b10}); end
    endtask

    task automatic test_reset_midstream;
        cycle(1'b0, 1'b1, 32'h003100B3);
        cycle(1'b1, 1'b1, 32'h123450B7);
        checks++; if ({out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm_I, imm_S, imm_B, imm_U, imm_J, imm} !== 225'd0) begin errors++; $display("FAIL mid_rst_data got=%h exp=0", {out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm_I, imm_S, imm_B, imm_U, imm_J, imm}); end
        checks++; if ({is_r, is_i, is_s, is_b, is_u, is_j, illegal} !== 7'd0) begin errors++; $display("FAIL mid_rst_flags got=%b exp=0000000", {is_r, is_i, is_s, is_b, is_u, is_j, illegal}); end
        cycle(1'b0, 1'b1, 32'h123450B7);
        checks++; if ({out_valid, imm, is_u} !== {1'b1, 32'h12345000, 1'b1}) begin errors++; $display("FAIL post_rst got=%h exp=%h", {out_valid, imm, is_u}, {1'b1, 32'h12345000, 1'b1}); end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        test_reset();
        test_r_type();
        test_i_type();
        test_i_variants();
        test_s_type();
        test_b_type();
        test_u_type();
        test_j_type();
        test_hold();
        test_illegal();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I instruction decoder stage with registered outputs.
- Splits a 32-bit instruction into opcode, register indices and function fields.
- Produces all five sign-extended immediate forms (I/S/B/U/J), a format-selected immediate, format flags and an illegal-opcode flag.
- Sits between instruction fetch and register-file read / execute.

Parameters:
- XLEN, 32, instruction and immediate width (only 32 supported).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  instruction input is valid this cycle
- instruction  input  32  raw RV32I instruction word
- out_valid  output  1  registered outputs hold a newly decoded instruction
- opcode  output  7  instruction[6:0]
- rd  output  5  instruction[11:7]
- funct3  output  3  instruction[14:12]
- rs1  output  5  instruction[19:15]
- rs2  output  5  instruction[24:20]
- funct7  output  7  instruction[31:25]
- imm_I  output  32  sign-extended instruction[31:20]
- imm_S  output  32  sign-extended {instruction[31:25], instruction[11:7]}
- imm_B  output  32  sign-extended {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}
- imm_U  output  32  {instruction[31:12], 12'b0}
- imm_J  output  32  sign-extended {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}
- imm  output  32  immediate selected by format
- is_r, is_i, is_s, is_b, is_u, is_j  output  1 each  one-hot format flags
- illegal  output  1  unrecognised opcode or instruction[1:0] != 2'b11

Behaviour:
- All outputs are registered.
- Latency is 1 cycle: the instruction sampled at clock edge N appears on the outputs after edge N.
- Reset (synchronous, rst high at a rising edge):
  - all outputs become 0, including out_valid and illegal;
  - rst has priority over instr_valid;
  - asserting rst mid-stream discards the pending decode.
- instr_valid=1 at an edge: all fields, immediates and flags update; out_valid<=1.
- instr_valid=0 at an edge: out_valid<=0; all other outputs hold their previous values.
- Field and immediate extraction is unconditional: every field and every imm_* is computed regardless of opcode.
- Sign extension always uses instruction[31].
- imm_B and imm_J always have bit 0 = 0; imm_U always has bits [11:0] = 0.
- Format classification by opcode:
  - 0110011 (OP) -> R
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR), 0001111 (MISC-MEM), 1110011 (SYSTEM) -> I
  - 0100011 (STORE) -> S
  - 1100011 (BRANCH) -> B
  - 0110111 (LUI), 0010111 (AUIPC) -> U
  - 1101111 (JAL) -> J
- imm selection:
  - I format -> imm_I; S -> imm_S; B -> imm_B; U -> imm_U; J -> imm_J;
  - R format or illegal -> 0.
- Illegal handling:
  - illegal=1 when the opcode is not in the list above, or when instruction[1:0] != 2'b11;
  - when illegal=1, all format flags are 0; raw fields and imm_* are still decoded.
- Exactly one format flag is 1 whenever illegal=0.
- No funct3/funct7 legality checking.

Test Plan:
- Reset, then ADD x1,x2,x3 (0x003100B3) with instr_valid=1 -> next cycle out_valid=1, opcode=0110011, rd=1, funct3=0, rs1=2, rs2=3, funct7=0, imm_I=0x00000003, is_r=1, imm=0.
- ADDI x1,x2,100 (0x06410093) -> imm_I=0x00000064, rd=1, rs1=2, is_i=1, imm=0x00000064; ADDI with immediate 0xFFF (0xFFF10093) -> imm_I=0xFFFFFFFF.
- SW x3,8(x2) (0x00312423) -> imm_S=0x00000008, rs1=2, rs2=3, is_s=1.
- BEQ encoding 0x04208163 -> imm_B=0x00000042, rs1=1, rs2=2, is_b=1.
- LUI x1,0x12345 (0x123450B7) -> imm_U=0x12345000, rd=1, is_u=1.
- JAL encoding 0x00A0A0EF -> imm_J=0x0000A00A, rd=1, is_j=1.
- Drop instr_valid -> out_valid=0 and fields hold.
- Instruction 0x00000000 -> illegal=1, all format flags 0.
- rst asserted while instr_valid=1 -> all outputs 0 on the next cycle.
